// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwards EX/MEM and MEM/WB results, selects ALU operands,
// blocks on load-use hazards and registers a/b/aluc behind a valid/ready handshake.
module alu_operand_stage #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             rs_addr,
    input  logic [4:0]             rt_addr,
    input  logic [31:0]            rs_data,
    input  logic [31:0]            rt_data,
    input  logic [15:0]            imm16,
    input  logic [4:0]             shamt,
    input  logic [3:0]             alu_op,
    input  logic [1:0]             a_sel,
    input  logic [1:0]             b_sel,
    input  logic                   exm_wen,
    input  logic                   exm_is_load,
    input  logic [4:0]             exm_waddr,
    input  logic [31:0]            exm_wdata,
    input  logic                   mwb_wen,
    input  logic [4:0]             mwb_waddr,
    input  logic [31:0]            mwb_wdata,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            a,
    output logic [31:0]            b,
    output logic [3:0]             aluc,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;
    logic [31:0] a_nxt;
    logic [31:0] b_nxt;
    logic        rs_used;
    logic        rt_used;
    logic        rs_load_hit;
    logic        rt_load_hit;
    logic        hazard;
    logic        capture;

    // EX/MEM takes priority over MEM/WB; r0 is hardwired to zero
    always_comb begin
        rs_fwd = rs_data;
        if (rs_addr == 5'd0)
            rs_fwd = '0;
        else if (exm_wen && (exm_waddr == rs_addr))
            rs_fwd = exm_wdata;
        else if (mwb_wen && (mwb_waddr == rs_addr))
            rs_fwd = mwb_wdata;
    end

    always_comb begin
        rt_fwd = rt_data;
        if (rt_addr == 5'd0)
            rt_fwd = '0;
        else if (exm_wen && (exm_waddr == rt_addr))
            rt_fwd = exm_wdata;
        else if (mwb_wen && (mwb_waddr == rt_addr))
            rt_fwd = mwb_wdata;
    end

    always_comb begin
        rs_used     = (a_sel == 2'd0) || (a_sel == 2'd2);
        rt_used     = (b_sel == 2'd0);
        rs_load_hit = rs_used && (exm_waddr == rs_addr);
        rt_load_hit = rt_used && (exm_waddr == rt_addr);
        hazard      = in_valid && exm_wen && exm_is_load && (exm_waddr != 5'd0)
                      && (rs_load_hit || rt_load_hit);
    end

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        a_nxt = '0;
        case (a_sel)
            2'd0:    a_nxt = rs_fwd;
            2'd1:    a_nxt = {27'd0, shamt};
            2'd2:    a_nxt = {27'd0, rs_fwd[4:0]};
            default: a_nxt = '0;
        endcase
    end

    always_comb begin
        b_nxt = '0;
        case (b_sel)
            2'd0:    b_nxt = rt_fwd;
            2'd1:    b_nxt = {{16{imm16[15]}}, imm16};
            2'd2:    b_nxt = {16'd0, imm16};
            default: b_nxt = '0;
        endcase
    end

    // A bubble needs no explicit branch: with a free slot and no capture, the drain path clears out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
            aluc      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            a         <= a_nxt;
            b         <= b_nxt;
            aluc      <= alu_op;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (hazard && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: stimulus pushes expected operands into a
// scoreboard queue, a monitor pops and compares on every output transfer.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic        exm_wen;
    logic        exm_is_load;
    logic [4:0]  exm_waddr;
    logic [31:0] exm_wdata;
    logic        mwb_wen;
    logic [4:0]  mwb_waddr;
    logic [31:0] mwb_wdata;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    alu_operand_stage #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .imm16(imm16), .shamt(shamt), .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel),
        .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_waddr(exm_waddr),
        .exm_wdata(exm_wdata), .mwb_wen(mwb_wen), .mwb_waddr(mwb_waddr),
        .mwb_wdata(mwb_wdata), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .a(a), .b(b), .aluc(aluc), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] ec);
        exp_t e;
        e.a    = ea;
        e.b    = eb;
        e.aluc = ec;
        sb.push_back(e);
    endtask

    task automatic idle();
        in_valid = 0; rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0;
        imm16 = 0; shamt = 0; alu_op = 0; a_sel = 0; b_sel = 0;
        exm_wen = 0; exm_is_load = 0; exm_waddr = 0; exm_wdata = 0;
        mwb_wen = 0; mwb_waddr = 0; mwb_wdata = 0; flush = 0; out_ready = 1;
    endtask

    // Inputs change on the falling edge; this samples 1 time unit later,
    // so out_valid && out_ready here means a transfer at the coming rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual a=%h b=%h aluc=%h required none", a, b, aluc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_a", a, e.a);
                    chk("sb_b", b, e.b);
                    chk("sb_aluc", {28'd0, aluc}, {28'd0, e.aluc});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_aluc", {28'd0, aluc}, 0);
        chk("rst_stall", {16'd0, stall_cnt}, 0);
        rst_n = 1;

        // forwarding priority
        @(negedge clk);
        in_valid = 1; rs_addr = 5; rs_data = 32'h99; a_sel = 0; b_sel = 3; alu_op = 4'h2;
        exm_wen = 1; exm_waddr = 5; exm_wdata = 32'h11;
        mwb_wen = 1; mwb_waddr = 5; mwb_wdata = 32'h22;
        push(32'h11, 0, 4'h2);
        #1 chk("fwd_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        exm_wen = 0; alu_op = 4'h3;
        push(32'h22, 0, 4'h3);
        @(negedge clk);
        rs_addr = 0; alu_op = 4'h4;
        push(0, 0, 4'h4);

        // immediate / shamt selection
        @(negedge clk);
        idle();
        in_valid = 1; a_sel = 3; b_sel = 1; imm16 = 16'h8001; alu_op = 4'h1;
        push(0, 32'hFFFF8001, 4'h1);
        @(negedge clk);
        b_sel = 2; alu_op = 4'h7;
        push(0, 32'h00008001, 4'h7);
        @(negedge clk);
        a_sel = 1; shamt = 31; b_sel = 3; alu_op = 4'h8;
        push(32'h1F, 0, 4'h8);
        @(negedge clk);
        a_sel = 2; rs_addr = 3; rs_data = 32'hABCDEF37; shamt = 0; alu_op = 4'h9;
        push(32'h17, 0, 4'h9);

        // load-use
        @(negedge clk);
        idle();
        in_valid = 1; a_sel = 3; b_sel = 1; rt_addr = 7; imm16 = 16'h0004; alu_op = 4'hA;
        exm_wen = 1; exm_is_load = 1; exm_waddr = 7; exm_wdata = 32'hDEAD;
        push(0, 32'h4, 4'hA);
        #1 chk("load_unused_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        b_sel = 0; rt_data = 32'h70; alu_op = 4'hB;
        #1 chk("load_use_ready", {31'd0, in_ready}, 0);
        chk("stall_before", {16'd0, stall_cnt}, 0);
        @(negedge clk);
        chk("bubble_valid", {31'd0, out_valid}, 0);
        chk("stall_inc", {16'd0, stall_cnt}, 1);
        exm_wen = 0; exm_is_load = 0;
        push(0, 32'h70, 4'hB);
        #1 chk("after_load_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        idle();
        in_valid = 1; exm_wen = 1; exm_is_load = 1; exm_waddr = 0; a_sel = 0; b_sel = 3; alu_op = 4'hC;
        push(0, 0, 4'hC);
        #1 chk("load_r0_ready", {31'd0, in_ready}, 1);

        // backpressure
        @(negedge clk);
        idle();
        in_valid = 1; rs_addr = 9; rs_data = 32'h100; rt_addr = 10; rt_data = 32'h200; alu_op = 4'h5;
        push(32'h100, 32'h200, 4'h5);
        @(negedge clk);
        out_ready = 0; rs_data = 32'h300; rt_data = 32'h400; alu_op = 4'h6;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'd0, in_ready}, 0);
            chk("bp_a", a, 32'h100);
            chk("bp_b", b, 32'h200);
            chk("bp_aluc", {28'd0, aluc}, 5);
            @(negedge clk);
        end
        out_ready = 1;
        push(32'h300, 32'h400, 4'h6);
        #1 chk("bp_release_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        idle();

        // flush against a capture, then normal resume
        @(negedge clk);
        in_valid = 1; flush = 1; rs_addr = 1; rs_data = 32'h55; alu_op = 4'hD;
        @(negedge clk);
        chk("flush_valid", {31'd0, out_valid}, 0);
        flush = 0; rs_data = 32'h66; alu_op = 4'hE;
        push(32'h66, 0, 4'hE);
        @(negedge clk);
        idle();

        // flush against a held output
        @(negedge clk);
        in_valid = 1; out_ready = 0; rs_addr = 2; rs_data = 32'h77; alu_op = 4'hF;
        @(negedge clk);
        chk("held_valid", {31'd0, out_valid}, 1);
        chk("held_a", a, 32'h77);
        in_valid = 0; flush = 1;
        @(negedge clk);
        chk("flush_hold_valid", {31'd0, out_valid}, 0);
        flush = 0; out_ready = 1;

        // asynchronous reset mid-stream
        @(negedge clk);
        in_valid = 1; out_ready = 0; rs_addr = 4; rs_data = 32'h1234; alu_op = 4'h3;
        @(negedge clk);
        in_valid = 0;
        chk("pre_rst_valid", {31'd0, out_valid}, 1);
        #3 rst_n = 0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 0);
        chk("arst_a", a, 0);
        chk("arst_b", b, 0);
        chk("arst_aluc", {28'd0, aluc}, 0);
        chk("arst_stall", {16'd0, stall_cnt}, 0);
        @(negedge clk);
        rst_n = 1;
        idle();
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
